mux2t1_arbiter: RTL and testbench
=================================

# mux2t1_arbiter

Two-requester round-robin arbiter that owns the select line of the existing `mux2t1` cell and shares it between requester A and requester B. It grants one requester at a time and limits how long a grant is held while the other side waits. It registers the selected data bit as its output. It sits between two independent single-bit sources and one shared single-bit consumer.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other requester waits; legal range 1..2^CNT_W.
- `CNT_W`, default 3: hold-counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_a` in 1: requester A wants the mux, level-sensitive.
- `req_b` in 1: requester B wants the mux, level-sensitive.
- `a` in 1: requester A data.
- `b` in 1: requester B data.
- `gnt_a` out 1: A holds the grant.
- `gnt_b` out 1: B holds the grant.
- `sel` out 1: mux select; 0 selects A, 1 selects B.
- `o` out 1: registered mux output.
- `busy` out 1: a grant is active.

## Operation
- States: IDLE, GRANT_A, GRANT_B.
- Internal registers:
  - `cnt` [CNT_W-1:0]: grant-cycle counter.
  - `last`: last requester served; 0 = A, 1 = B.
- IDLE:
  - Only `req_a` -> GRANT_A.
  - Only `req_b` -> GRANT_B.
  - Both -> grant the side not equal to `last`.
  - Neither -> stay in IDLE.
- GRANT_A:
  - `!req_a` and `req_b` -> GRANT_B directly, with no IDLE bubble.
  - `!req_a` and `!req_b` -> IDLE.
  - `req_a` and `req_b` and `cnt == MAX_HOLD-1` -> GRANT_B (pre-emption).
  - Otherwise stay in GRANT_A.
- GRANT_B: mirror image of GRANT_A.
- Counter:
  - `cnt` clears to 0 on every state change.
  - `cnt` increments each cycle the state stays in GRANT_x.
  - `cnt` saturates at MAX_HOLD-1. If a requester holds the grant alone past the limit, a newly arriving contender therefore takes over on the next edge.
- `last` updates on entry to GRANT_A (0) or GRANT_B (1); it is unchanged on entry to IDLE.
- With MAX_HOLD = 1 and both requesting, the grant alternates every cycle.
- Output decodes, all registered or driven only from registered state:
  - `gnt_a` = (state == GRANT_A).
  - `gnt_b` = (state == GRANT_B).
  - `sel` = `gnt_b`.
  - `busy` = `gnt_a | gnt_b`.
- Data: at each edge, `o` <= `mux2t1(sel, a, b)` when the current (pre-edge) state is GRANT_x; `o` <= 0 when the current state is IDLE.
- Reset values: state IDLE, `cnt` 0, `last` 1 (A wins the first tie), and all outputs 0.
- Reset mid-grant: all outputs drop to 0 asynchronously, with no glitch back. The first post-reset grant follows the IDLE rules.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled at edge N gives a grant visible after edge N.
- `o` lags the grant by 1 cycle. Data sampled at edge N+1 under grant appears after edge N+1.
- Release: deasserting `req_x` at edge N drops `gnt_x` after edge N. A waiting contender is granted at that same edge.
- Simultaneous release by one side and a new request from the other: handoff happens in one edge.
- No combinational path from any input to any output.

## Structure
- Shared package/include `mux_pkg`:
  - State encoding localparams: IDLE = 2'b00, GRANT_A = 2'b01, GRANT_B = 2'b10.
  - Default MAX_HOLD and CNT_W.
- One sub-module: the existing `mux2t1` cell, instantiated for the data path (`sel`, `a`, `b` -> `o` register input).
- State register, counter and `last` are in this module.

## Test plan
- Reset mid-grant: while `gnt_a = 1`, pull `rst_n` low between edges -> `gnt_a`, `sel`, `o`, `busy` read 0 immediately. Then release reset, assert `req_b` -> `gnt_b = 1` one edge later.
- Single requester: `req_a = 1`, `a = 1` from cycle 0 -> `gnt_a = 1` after edge 1, `o = 1` after edge 2. Toggling `a` is tracked on `o` with 1-cycle lag.
- Tie after reset, MAX_HOLD = 4: `req_a = req_b = 1` held -> `gnt_a` for 4 cycles, `gnt_b` for 4, `gnt_a` for 4, and so on. `sel` tracks `gnt_b`.
- Handoff: while in GRANT_A with `req_b = 1`, drop `req_a` -> `gnt_b = 1` on the very next edge, with `busy` never 0.
- Saturation: `req_a` alone for 10 cycles, then `req_b` rises -> `gnt_b = 1` one edge later.
- MAX_HOLD = 1, both requesting -> grant alternates A, B, A, B every cycle.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared state encoding and default sizing for mux2t1_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT_A = 2'b01;
    localparam logic [1:0] GRANT_B = 2'b10;

    localparam int DEF_MAX_HOLD = 4;
    localparam int DEF_CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT_A = GRANT_A,
        ST_GRANT_B = GRANT_B
    } state_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux2t1.sv
`default_nettype none
// ============================================================================
// Module      : mux2t1
// Description : Existing 2:1 single-bit mux cell; sel=0 picks a, sel=1 picks b.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2t1 (
    input  logic sel,
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = sel ? b : a;

endmodule : mux2t1
`default_nettype wire

// File: rtl/mux2t1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2t1_arbiter
// Description : Two-requester round-robin arbiter with bounded hold time that
//               drives the mux2t1 select and registers the selected data bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2t1_arbiter
    import mux_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic a,
    input  logic b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic o,
    output logic busy
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             o_q, o_d;
    logic             mux_y;
    logic             hold_expired;

    mux2t1 u_mux2t1 (
        .sel (sel),
        .a   (a),
        .b   (b),
        .y   (mux_y)
    );

    // cnt saturates, so a lone holder that overstays is pre-empted on the
    // first edge at which the other side shows up.
    assign hold_expired = (cnt_q == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_q ? ST_GRANT_A : ST_GRANT_B;
                end else if (req_a) begin
                    state_d = ST_GRANT_A;
                end else if (req_b) begin
                    state_d = ST_GRANT_B;
                end
            end
            ST_GRANT_A: begin
                if (!req_a) begin
                    state_d = req_b ? ST_GRANT_B : ST_IDLE;
                end else if (req_b && hold_expired) begin
                    state_d = ST_GRANT_B;
                end
            end
            ST_GRANT_B: begin
                if (!req_b) begin
                    state_d = req_a ? ST_GRANT_A : ST_IDLE;
                end else if (req_a && hold_expired) begin
                    state_d = ST_GRANT_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == ST_GRANT_A) begin
                last_d = 1'b0;
            end else if (state_d == ST_GRANT_B) begin
                last_d = 1'b1;
            end
        end else if (state_q != ST_IDLE && !hold_expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        o_d = 1'b0;
        if (state_q != ST_IDLE) begin
            o_d = mux_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            o_q     <= o_d;
        end
    end

    assign gnt_a = (state_q == ST_GRANT_A);
    assign gnt_b = (state_q == ST_GRANT_B);
    assign sel   = gnt_b;
    assign busy  = gnt_a | gnt_b;
    assign o     = o_q;

endmodule : mux2t1_arbiter
`default_nettype wire

// File: tb/tb_mux2t1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2t1_arbiter
// Description : Self-checking bench for mux2t1_arbiter (MAX_HOLD 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2t1_arbiter;

    logic clk = 1'b0;
    logic rst_n, req_a, req_b, a, b;
    logic gnt_a4, gnt_b4, sel4, o4, busy4;
    logic gnt_a1, gnt_b1, sel1, o1, busy1;

    int vectors = 0;
    int fails   = 0;

    // Reference model per instance: owner 0=none 1=A 2=B, held = cycles owned.
    int m_own  [2];
    int m_held [2];
    int m_last [2];
    int m_o    [2];
    int m_max  [2] = '{4, 1};

    always #5 clk = ~clk;

    mux2t1_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a4), .gnt_b(gnt_b4), .sel(sel4), .o(o4), .busy(busy4)
    );

    mux2t1_arbiter #(.MAX_HOLD(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .o(o1), .busy(busy1)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = 0;
            m_held[k] = 0;
            m_last[k] = 2;
            m_o[k]    = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nxt;
            m_o[k] = (m_own[k] == 1) ? int'(a) : (m_own[k] == 2) ? int'(b) : 0;
            nxt = m_own[k];
            if (m_own[k] == 0) begin
                if (req_a && req_b) nxt = (m_last[k] == 2) ? 1 : 2;
                else if (req_a)     nxt = 1;
                else if (req_b)     nxt = 2;
            end else begin
                bit mine   = (m_own[k] == 1) ? req_a : req_b;
                bit theirs = (m_own[k] == 1) ? req_b : req_a;
                int other  = 3 - m_own[k];
                if (!mine)                                 nxt = theirs ? other : 0;
                else if (theirs && m_held[k] >= m_max[k]) nxt = other;
            end
            if (nxt != m_own[k]) begin
                m_held[k] = (nxt != 0) ? 1 : 0;
                if (nxt != 0) m_last[k] = nxt;
                m_own[k] = nxt;
            end else if (m_own[k] != 0) begin
                m_held[k]++;
            end
        end
    endtask

    function automatic logic [4:0] exp_vec(input int k);
        return {m_own[k] == 1, m_own[k] == 2, m_own[k] == 2, m_own[k] != 0, m_o[k] != 0};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed{gnt_a,gnt_b,sel,busy,o}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/hold4"}, {gnt_a4, gnt_b4, sel4, busy4, o4}, exp_vec(0));
        check({tag, "/hold1"}, {gnt_a1, gnt_b1, sel1, busy1, o1}, exp_vec(1));
    endtask

    task automatic drive(input logic ra, input logic rb, input logic da, input logic db);
        req_a = ra;
        req_b = rb;
        a     = da;
        b     = db;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic step(input string tag, input logic ra, input logic rb,
                        input logic da, input logic db);
        @(negedge clk);
        drive(ra, rb, da, db);
        tick(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("idle", 1'b0, 1'b0, 1'b1, 1'b1);

        // Single requester with data toggling.
        step("single_a", 1'b1, 1'b0, 1'b1, 1'b0);
        step("single_a", 1'b1, 1'b0, 1'b1, 1'b0);
        step("single_a", 1'b1, 1'b0, 1'b0, 1'b1);
        step("single_a", 1'b1, 1'b0, 1'b1, 1'b0);
        step("single_a", 1'b1, 1'b0, 1'b0, 1'b0);
        step("release_a", 1'b0, 1'b0, 1'b1, 1'b1);

        // Tie from reset: A wins first, then rotation.
        do_reset("reset_tie");
        for (int i = 0; i < 20; i++) begin
            step("tie", 1'b1, 1'b1, i[0], ~i[1]);
        end

        // Direct handoff A -> B without IDLE.
        do_reset("reset_handoff");
        step("handoff_a", 1'b1, 1'b0, 1'b1, 1'b0);
        step("handoff_wait", 1'b1, 1'b1, 1'b1, 1'b0);
        step("handoff_b", 1'b0, 1'b1, 1'b0, 1'b1);
        step("handoff_b", 1'b0, 1'b1, 1'b0, 1'b1);
        step("handoff_back", 1'b1, 1'b0, 1'b1, 1'b1);

        // Saturation: long lone hold, then contender takes over next edge.
        do_reset("reset_sat");
        for (int i = 0; i < 10; i++) begin
            step("sat_a", 1'b1, 1'b0, 1'b1, 1'b0);
        end
        step("sat_b_arrives", 1'b1, 1'b1, 1'b1, 1'b0);
        step("sat_b", 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset mid-grant between edges, then B requests after release.
        step("pre_rst", 1'b1, 1'b0, 1'b1, 1'b1);
        step("pre_rst", 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid_grant");
        @(negedge clk);
        check_all("rst_held");
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick("rst_release_b");
        step("post_rst_b", 1'b0, 1'b1, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("random", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_mux2t1_arbiter
`default_nettype wire
